// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller that sits beside the IF/ID and ID/EX registers.
//   It detects three kinds of hazard:
//     - load-use hazards, stalling for LOAD_LAT cycles
//     - mul/div structural hazards (a new mult/div while the unit is busy)
//     - HI/LO read hazards (mfhi/mflo while the unit is busy)
//   It also squashes the fetched instruction when a branch in ID is taken.
//
// Parameters
//   REG_W         register-address width
//   LOAD_LAT      stall cycles per load-use hazard (1..4)
//   MULDIV_CYCLES mul/div busy cycles after issue (2..32)
//   CNT_W         stall performance counter width
//
// Ports
//   Clk, Rst          rising-edge clock; asynchronous active-low reset
//   RS_ID/RT_ID       source registers of the ID instruction
//   UsesRS_ID/RT_ID   ID instruction actually reads rs / rt
//   RT_EX, MemRead_EX destination register of the EX instruction, and a flag
//                     that EX holds a load
//   BranchTaken_ID    branch/jump in ID resolved taken
//   MulDivStart_ID    ID instruction is mult/div
//   ReadsHiLo_ID      ID instruction is mfhi/mflo
//   StallCountClr     synchronous clear of StallCount
//   Stall             hold PC and IF/ID
//   FlushID           bubble into ID/EX
//   FlushIF           squash IF/ID
//   MulDivBusy        mul/div unit occupied (registered)
//   StallCount        saturating count of stalled cycles (registered)
module hazard_control_unit #(
   parameter int REG_W         = 5,
   parameter int LOAD_LAT      = 1,
   parameter int MULDIV_CYCLES = 8,
   parameter int CNT_W         = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [REG_W-1:0] RS_ID,
   input  logic [REG_W-1:0] RT_ID,
   input  logic             UsesRS_ID,
   input  logic             UsesRT_ID,
   input  logic [REG_W-1:0] RT_EX,
   input  logic             MemRead_EX,
   input  logic             BranchTaken_ID,
   input  logic             MulDivStart_ID,
   input  logic             ReadsHiLo_ID,
   input  logic             StallCountClr,
   output logic             Stall,
   output logic             FlushID,
   output logic             FlushIF,
   output logic             MulDivBusy,
   output logic [CNT_W-1:0] StallCount
);

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);
   localparam logic [5:0] MD_CYC = 6'(MULDIV_CYCLES);

   state_t     state, state_nxt;
   logic [1:0] lcnt, lcnt_nxt;
   logic [5:0] mcnt;
   logic       lu, md, load_stall, stall_int;

   // Register 0 is hard-wired, so a load targeting it can never create a hazard.
   assign lu = MemRead_EX & (RT_EX != '0) &
               ((UsesRS_ID & (RT_EX == RS_ID)) | (UsesRT_ID & (RT_EX == RT_ID)));

   assign MulDivBusy = (mcnt != 6'd0);
   assign md         = MulDivBusy & (ReadsHiLo_ID | MulDivStart_ID);

   // Load FSM: the first stall cycle comes from IDLE itself. LOAD_WAIT covers
   // the remaining LOAD_LAT-1 cycles. During those cycles EX holds the bubble,
   // so LU is ignored.
   always_comb begin
      state_nxt  = state;
      lcnt_nxt   = lcnt;
      load_stall = 1'b0;
      case (state)
         IDLE: begin
            if (lu) begin
               load_stall = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_nxt = LOAD_WAIT;
                  lcnt_nxt  = LAT_M1;
               end
            end
         end
         LOAD_WAIT: begin
            load_stall = 1'b1;
            lcnt_nxt   = lcnt - 2'd1;
            if (lcnt == 2'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stall_int = load_stall | md;

   // Gate the combinational outputs with reset so that live hazard inputs
   // cannot leak through while the block is held in reset.
   assign Stall   = Rst & stall_int;
   assign FlushID = Stall;
   // A stall keeps the branch in ID. It is re-evaluated once the stall clears.
   assign FlushIF = Rst & BranchTaken_ID & ~stall_int;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         lcnt  <= 2'd0;
      end else begin
         state <= state_nxt;
         lcnt  <= lcnt_nxt;
      end
   end

   // A stalled mult/div does not issue. It reloads the counter only on the
   // first unstalled cycle.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                        mcnt <= 6'd0;
      else if (MulDivStart_ID & ~Stall) mcnt <= MD_CYC;
      else if (mcnt != 6'd0)           mcnt <= mcnt - 6'd1;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                              StallCount <= '0;
      else if (StallCountClr)                StallCount <= '0;
      else if (Stall && (StallCount != '1))  StallCount <= StallCount + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit.
// Three instances share the same stimulus:
//   dut 0: LOAD_LAT=1, CNT_W=16
//   dut 1: LOAD_LAT=3, CNT_W=4
//   dut 2: LOAD_LAT=4, CNT_W=16
// The stimulus process drives one row per cycle just after the rising edge.
// It pushes the hand-computed expectations for that row into a queue. A
// monitor samples the outputs on the falling edge and compares them against
// the queue entries tagged with the current cycle.
module tb_hazard_control_unit;

   logic       Clk, Rst;
   logic [4:0] RS_ID, RT_ID, RT_EX;
   logic       UsesRS_ID, UsesRT_ID, MemRead_EX, BranchTaken_ID;
   logic       MulDivStart_ID, ReadsHiLo_ID, StallCountClr;

   logic        st  [3];
   logic        fid [3];
   logic        fif [3];
   logic        bsy [3];
   logic [15:0] cnt_a, cnt_c;
   logic [3:0]  cnt_b;

   hazard_control_unit #(.REG_W(5), .LOAD_LAT(1), .MULDIV_CYCLES(8), .CNT_W(16)) u_a (
      .Clk(Clk), .Rst(Rst), .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID),
      .UsesRT_ID(UsesRT_ID), .RT_EX(RT_EX), .MemRead_EX(MemRead_EX),
      .BranchTaken_ID(BranchTaken_ID), .MulDivStart_ID(MulDivStart_ID),
      .ReadsHiLo_ID(ReadsHiLo_ID), .StallCountClr(StallCountClr),
      .Stall(st[0]), .FlushID(fid[0]), .FlushIF(fif[0]), .MulDivBusy(bsy[0]),
      .StallCount(cnt_a));

   hazard_control_unit #(.REG_W(5), .LOAD_LAT(3), .MULDIV_CYCLES(8), .CNT_W(4)) u_b (
      .Clk(Clk), .Rst(Rst), .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID),
      .UsesRT_ID(UsesRT_ID), .RT_EX(RT_EX), .MemRead_EX(MemRead_EX),
      .BranchTaken_ID(BranchTaken_ID), .MulDivStart_ID(MulDivStart_ID),
      .ReadsHiLo_ID(ReadsHiLo_ID), .StallCountClr(StallCountClr),
      .Stall(st[1]), .FlushID(fid[1]), .FlushIF(fif[1]), .MulDivBusy(bsy[1]),
      .StallCount(cnt_b));

   hazard_control_unit #(.REG_W(5), .LOAD_LAT(4), .MULDIV_CYCLES(8), .CNT_W(16)) u_c (
      .Clk(Clk), .Rst(Rst), .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRS_ID(UsesRS_ID),
      .UsesRT_ID(UsesRT_ID), .RT_EX(RT_EX), .MemRead_EX(MemRead_EX),
      .BranchTaken_ID(BranchTaken_ID), .MulDivStart_ID(MulDivStart_ID),
      .ReadsHiLo_ID(ReadsHiLo_ID), .StallCountClr(StallCountClr),
      .Stall(st[2]), .FlushID(fid[2]), .FlushIF(fif[2]), .MulDivBusy(bsy[2]),
      .StallCount(cnt_c));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int          cyc;
      int          dut;
      logic        stall;
      logic        fif;
      logic        busy;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   cur_cyc = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;

   // Monitor: pops every expectation belonging to the current cycle.
   initial begin : monitor
      exp_t        e;
      logic [15:0] c;
      forever begin
         @(negedge Clk);
         while (q.size() > 0 && q[0].cyc == cur_cyc) begin
            e = q.pop_front();
            case (e.dut)
               0:       c = cnt_a;
               1:       c = {12'd0, cnt_b};
               default: c = cnt_c;
            endcase
            n_cmp++;
            if ({st[e.dut], fid[e.dut], fif[e.dut], bsy[e.dut], c} !==
                {e.stall, e.stall, e.fif, e.busy, e.cnt}) begin
               n_bad++;
               $display("FAIL %s dut%0d cyc%0d: got stall=%b flushid=%b flushif=%b busy=%b cnt=%0d, want stall=%b flushid=%b flushif=%b busy=%b cnt=%0d",
                        e.tag, e.dut, e.cyc, st[e.dut], fid[e.dut], fif[e.dut], bsy[e.dut], c,
                        e.stall, e.stall, e.fif, e.busy, e.cnt);
            end
         end
      end
   end

   // Drive one row: (rst, memread, rt_ex, rs, uses_rs, rt, uses_rt, branch, muldiv, hilo, clr)
   task automatic cyc(input logic rst, input logic mr, input logic [4:0] rtex,
                      input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic br, input logic mds,
                      input logic hl, input logic clr);
      @(posedge Clk);
      #1;
      Rst = rst; MemRead_EX = mr; RT_EX = rtex; RS_ID = rs; UsesRS_ID = urs;
      RT_ID = rt; UsesRT_ID = urt; BranchTaken_ID = br; MulDivStart_ID = mds;
      ReadsHiLo_ID = hl; StallCountClr = clr;
      cur_cyc++;
   endtask

   task automatic idle();               cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask
   task automatic idle_clr();           cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   endtask
   // Load to r5 in EX while ID reads r5 through rs.
   task automatic lu(input logic br, input logic clr);
      cyc(1, 1, 5, 5, 1, 0, 0, br, 0, 0, clr);
   endtask

   task automatic ex(input int dut, input logic s, input logic f, input logic b,
                     input int c, input string tag);
      exp_t e;
      e.cyc = cur_cyc; e.dut = dut; e.stall = s; e.fif = f; e.busy = b;
      e.cnt = 16'(c); e.tag = tag;
      q.push_back(e);
   endtask

   task automatic ex_all_zero(input string tag);
      for (int d = 0; d < 3; d++) ex(d, 0, 0, 0, 0, tag);
   endtask

   initial begin : stim
      Rst = 0; MemRead_EX = 0; RT_EX = 0; RS_ID = 0; RT_ID = 0; UsesRS_ID = 0;
      UsesRT_ID = 0; BranchTaken_ID = 0; MulDivStart_ID = 0; ReadsHiLo_ID = 0;
      StallCountClr = 0;

      // Reset, then load-use hazards at latencies 1, 3 and 4.
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex_all_zero("in_reset");
      idle();                                ex(0, 0, 0, 0, 0, "post_release");
      lu(0, 0);   ex(0, 1, 0, 0, 0, "lu_a"); ex(1, 1, 0, 0, 0, "lu_b"); ex(2, 1, 0, 0, 0, "lu_c");
      cyc(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0);  // RT_EX now r0: no new hazard
      ex(0, 0, 0, 0, 1, "lat1_done"); ex(1, 1, 0, 0, 1, "lat3_wait"); ex(2, 1, 0, 0, 1, "lat4_wait");
      idle();     ex(0, 0, 0, 0, 1, "lat1_idle"); ex(1, 1, 0, 0, 2, "lat3_wait2"); ex(2, 1, 0, 0, 2, "lat4_wait2");
      idle();     ex(1, 0, 0, 0, 3, "lat3_done"); ex(2, 1, 0, 0, 3, "lat4_wait3");
      idle();     ex(1, 0, 0, 0, 3, "lat3_idle"); ex(2, 0, 0, 0, 4, "lat4_done");
      cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      ex(0, 0, 0, 0, 1, "r0_a"); ex(1, 0, 0, 0, 3, "r0_b"); ex(2, 0, 0, 0, 4, "r0_c");
      cyc(1, 1, 7, 3, 1, 7, 1, 0, 0, 0, 0);  ex(0, 1, 0, 0, 1, "lu_rt");
      cyc(1, 1, 7, 7, 0, 7, 0, 0, 0, 0, 0);  ex(0, 0, 0, 0, 2, "uses_off");
      idle();     ex(0, 0, 0, 0, 2, "idle_a");  ex(1, 1, 0, 0, 5, "lat3_wait_b");
      idle();     ex(1, 0, 0, 0, 6, "lat3_end_b"); ex(2, 1, 0, 0, 7, "lat4_wait_c");
      idle_clr(); ex(0, 0, 0, 0, 2, "pre_clr_a"); ex(1, 0, 0, 0, 6, "pre_clr_b"); ex(2, 0, 0, 0, 8, "pre_clr_c");
      idle();     ex_all_zero("post_clr");

      // Branch versus stall.
      lu(1, 0);   ex(0, 1, 0, 0, 0, "br_vs_lu");
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      ex(0, 0, 1, 0, 1, "br_after"); ex(1, 1, 0, 0, 1, "br_vs_wait_b"); ex(2, 1, 0, 0, 1, "br_vs_wait_c");
      idle();     ex(0, 0, 0, 0, 1, "br_idle"); ex(1, 1, 0, 0, 2, "br_wait_b");
      idle();     ex(1, 0, 0, 0, 3, "br_end_b"); ex(2, 1, 0, 0, 3, "br_wait_c");
      idle();     ex(0, 0, 0, 0, 1, "br_cnt_a"); ex(1, 0, 0, 0, 3, "br_cnt_b"); ex(2, 0, 0, 0, 4, "br_cnt_c");
      idle_clr();

      // Mul/div issue, then mfhi while busy.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); ex(0, 0, 0, 0, 0, "md_issue");
      idle();                                ex(0, 0, 0, 1, 0, "md_busy");
      for (int k = 2; k <= 8; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); ex(0, 1, 0, 1, k - 2, "md_hilo");
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  ex(0, 0, 0, 0, 7, "md_hilo_go");
      // Back-to-back mult/div: the second is held without reloading the counter.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  ex(0, 0, 0, 0, 7, "md_issue2");
      for (int k = 0; k < 8; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, (k == 0), 1, 0, 0); ex(0, 1, 0, 1, 7 + k, "md_held");
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  ex(0, 0, 0, 0, 15, "md_reissue");
      lu(0, 0);                              ex(0, 1, 0, 1, 15, "lu_with_busy");

      // Asynchronous reset mid LOAD_WAIT (dut 2) and mid mul/div, with live hazards.
      cyc(0, 1, 5, 5, 1, 0, 0, 1, 1, 1, 0);  ex_all_zero("async_rst");
      idle();                                ex_all_zero("rst_release");
      idle();                                ex_all_zero("no_residual");

      // Continuous stall: the 4-bit counter saturates, then clear beats increment.
      for (int k = 0; k < 20; k++) begin
         lu(0, 0); ex(0, 1, 0, 0, k, "cnt_a"); ex(1, 1, 0, 0, (k > 15) ? 15 : k, "sat_b");
      end
      lu(0, 1);   ex(0, 1, 0, 0, 20, "clr_pre_a"); ex(1, 1, 0, 0, 15, "clr_pre_b");
      lu(0, 0);   ex(0, 1, 0, 0, 0, "clr_wins_a"); ex(1, 1, 0, 0, 0, "clr_wins_b");
      idle();
      @(negedge Clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: %0d expectations never compared, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL timeout: bench still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor to the single-cycle load-use detector in the 5-stage pipeline; sits beside the IF/ID and ID/EX registers.
- Detects load-use hazards, including multi-cycle load latency, and mul/div structural and HI/LO hazards.
- Squashes the fetched instruction on a taken branch.
- Drives Stall (PC write and IF/ID write hold), FlushID (bubble into ID/EX), FlushIF (squash IF/ID) and a stall-cycle performance counter.

Parameters:
- REG_W, 5, register-address width.
- LOAD_LAT, 1, data-memory load latency in stall cycles per load-use hazard; legal range 1..4.
- MULDIV_CYCLES, 8, mul/div unit busy cycles after issue; legal range 2..32.
- CNT_W, 16, width of the stall performance counter.

Ports:
- Clk, in, 1, pipeline clock; rising edge.
- Rst, in, 1, asynchronous active-low reset.
- RS_ID, in, REG_W, rs of instruction in ID.
- RT_ID, in, REG_W, rt of instruction in ID.
- UsesRS_ID, in, 1, ID instruction reads rs.
- UsesRT_ID, in, 1, ID instruction reads rt.
- RT_EX, in, REG_W, destination of the load in EX.
- MemRead_EX, in, 1, EX instruction is a load.
- BranchTaken_ID, in, 1, branch/jump resolved taken in ID.
- MulDivStart_ID, in, 1, ID instruction is mult/div.
- ReadsHiLo_ID, in, 1, ID instruction is mfhi/mflo.
- StallCountClr, in, 1, synchronous clear of StallCount.
- Stall, out, 1, hold PC and IF/ID.
- FlushID, out, 1, zero control bits into ID/EX.
- FlushIF, out, 1, zero IF/ID instruction.
- MulDivBusy, out, 1, mul/div unit occupied.
- StallCount, out, CNT_W, saturating count of stalled cycles.

Behaviour:

Reset:
- While Rst=0, all state clears: FSM to IDLE, counters to 0.
- Outputs during reset: Stall=0, FlushID=0, FlushIF=0, MulDivBusy=0, StallCount=0.
- Reset may arrive mid-stall or mid-mul/div; state is abandoned with no residual stall after release.

Load-use hazard (combinational):
- LU = MemRead_EX & (RT_EX != 0) & ((UsesRS_ID & RT_EX==RS_ID) | (UsesRT_ID & RT_EX==RT_ID)).
- Register 0 never causes a hazard.

Load FSM, states IDLE and LOAD_WAIT, with counter lcnt of width 2:
- IDLE: if LU, Stall=FlushID=1 in the same cycle.
  - If LOAD_LAT>1, go to LOAD_WAIT with lcnt=LOAD_LAT-1.
  - If LOAD_LAT=1, stay in IDLE.
- LOAD_WAIT: Stall=FlushID=1 unconditionally, ignoring LU (EX holds a bubble). lcnt decrements each cycle; go to IDLE when lcnt==1.
- Total stall cycles per hazard = LOAD_LAT exactly.

Mul/div tracker, counter mcnt of width 6:
- On MulDivStart_ID & ~Stall, load mcnt=MULDIV_CYCLES.
- Otherwise, if mcnt!=0, decrement.
- MulDivBusy = (mcnt!=0).
- MD = MulDivBusy & (ReadsHiLo_ID | MulDivStart_ID). MD forces Stall=FlushID=1 that cycle.
- A stalled MulDivStart_ID does not reload mcnt; it issues on the first cycle with MulDivBusy=0 and no other stall.

Combined outputs:
- Stall = LU_stall | LOAD_WAIT | MD, where LU_stall is LU in IDLE.
- FlushID = Stall.

Branch flush:
- FlushIF = BranchTaken_ID & ~Stall, asserted the same cycle.
- When a branch and a stall coincide, the stall wins and FlushIF=0. The branch is held in ID and re-evaluated once the stall clears.

Performance counter:
- StallCount increments on each rising edge where Stall=1, saturating at 2^CNT_W-1.
- StallCountClr=1 loads 0 and wins over increment.

General:
- All outputs except StallCount are combinational from state and inputs, with no extra latency.
- MulDivBusy and StallCount are registered.

Test Plan:
- LOAD_LAT=1, MemRead_EX=1, RT_EX=5, RS_ID=5, UsesRS_ID=1 for one cycle -> Stall=FlushID=1 for exactly 1 cycle, then 0; StallCount=1.
- LOAD_LAT=3, same hazard, then RT_EX changed to 0 on the next cycle -> Stall=1 for 3 consecutive cycles regardless; StallCount=3. Repeat with RT_EX=0, RS_ID=0 -> no stall.
- MULDIV_CYCLES=8: MulDivStart_ID=1 at cycle 0, mfhi in ID at cycle 2 -> MulDivBusy=1 for cycles 1..8; Stall=1 in cycles 2..8; mfhi proceeds at cycle 9.
- BranchTaken_ID=1 coincident with a load-use hazard -> FlushIF=0 and Stall=1. Next cycle, with no hazard and BranchTaken_ID=1 -> FlushIF=1, Stall=0.
- Rst driven low mid LOAD_WAIT (LOAD_LAT=4) and mid mul/div -> all outputs 0 immediately without waiting for a clock edge; after release, no stall until a new hazard.
- CNT_W=4, 20 stall cycles -> StallCount saturates at 15. StallCountClr=1 during a stall -> StallCount=0 on the next edge.
